// File: rtl/sum_accum_pkg.sv
// Shared types and default sizing for the sum_accum block.
// Sample width is one bit wider than the adder operand to hold the carry out.
package sum_accum_pkg;

    localparam int SA_DW       = 4;
    localparam int SA_ACC_W    = 8;
    localparam int SA_BATCH    = 4;
    localparam int SA_SAMPLE_W = SA_DW + 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/sum_accum_if.sv
// Input (adder result) and output (batch total) handshakes of sum_accum.
// master = sample source / result consumer, slave = sum_accum itself.
interface sum_accum_if
    import sum_accum_pkg::*;
#(
    parameter int DW    = SA_DW,
    parameter int ACC_W = SA_ACC_W
);

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_sum;
    logic             in_co;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic [7:0]       out_cnt;

    modport master (
        output in_valid,
        output in_sum,
        output in_co,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_acc,
        input  out_ovf,
        input  out_cnt
    );

    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_co,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_acc,
        output out_ovf,
        output out_cnt
    );

endinterface

// File: rtl/sum_accum_add.sv
// Accumulator datapath: adds a zero-extended {co, sum} sample to acc.
// SUM_ACCUM_SAT_EN selects saturation at all-ones instead of wrap-around.
module sum_accum_add
    import sum_accum_pkg::*;
#(
    parameter int DW    = SA_DW,
    parameter int ACC_W = SA_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [DW:0]      sample,
    output logic [ACC_W-1:0] acc_nxt,
    output logic             ovf_bit
);

    logic [ACC_W:0] sum;

    always_comb begin
        sum = {1'b0, acc} + {{(ACC_W - DW){1'b0}}, sample};
`ifdef SUM_ACCUM_SAT_EN
        // once pinned at all-ones, any further add carries out again and stays pinned
        acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
        ovf_bit = sum[ACC_W];
    end

endmodule

// File: rtl/sum_accum.sv
// Batch accumulator behind the 4-bit adder stage; presents a total every BATCH samples.
// Optional saturation via SUM_ACCUM_SAT_EN (see sum_accum_add).
//
// state   | meaning
// ST_ACC  | accepting samples, in_ready=1, adding into acc
// ST_HOLD | batch total presented on out_*, waiting for out_ready
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int DW    = SA_DW,
    parameter int ACC_W = SA_ACC_W,
    parameter int BATCH = SA_BATCH
) (
    input logic            clk,
    input logic            rst_n,
    input logic            clr,
    sum_accum_if.slave     bus
);

    localparam logic [7:0] BATCH_CNT = 8'(BATCH);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [7:0]       cnt;
    logic             out_valid;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_bit;
    logic [7:0]       cnt_inc;
    logic             take;

    sum_accum_add #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_add (
        .acc     (acc),
        .sample  ({bus.in_co, bus.in_sum}),
        .acc_nxt (acc_nxt),
        .ovf_bit (ovf_bit)
    );

    assign cnt_inc = cnt + 8'd1;
    assign take    = bus.in_valid && (state == ST_ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            // out_acc/out_ovf intentionally keep the last presented result
            state     <= ST_ACC;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (take) begin
                        if (cnt_inc == BATCH_CNT) begin
                            out_acc   <= acc_nxt;
                            out_ovf   <= ovf | ovf_bit;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                            acc       <= '0;
                            ovf       <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            acc <= acc_nxt;
                            ovf <= ovf | ovf_bit;
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_ACC);
    assign bus.out_valid = out_valid;
    assign bus.out_acc   = out_acc;
    assign bus.out_ovf   = out_ovf;
    assign bus.out_cnt   = cnt;

endmodule

// File: doc/sum_accum.md
Name: sum_accum

Overview:
- Downstream consumer of the 4-bit ripple-carry adder stage.
- Captures each adder result ({Co, S}) through a valid/ready handshake and adds it into a wider running accumulator.
- After BATCH accepted samples it presents the total plus a sticky overflow flag on an output valid/ready port.
- Sits between the combinational adder and the display/readout logic of the lab top.

Parameters:
- DW, 4, adder operand width; an input sample is DW+1 bits ({in_co, in_sum}).
- ACC_W, 8, accumulator width; must be greater than DW+1.
- BATCH, 4, number of samples accumulated per result; range 1..255.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; discards the batch in progress and any pending output.
- in_valid  input  1  adder result present.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  DW  adder sum S.
- in_co  input  1  adder carry out.
- out_valid  output  1  batch result available.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  accumulated total.
- out_ovf  output  1  the total exceeded 2^ACC_W-1 during this batch.
- out_cnt  output  8  samples accepted in the current batch.

Behaviour:
- Reset (async assert, sync release): state=ACC, acc=0, ovf=0, cnt=0, out_valid=0, out_acc=0, out_ovf=0.
  - in_ready is combinational: (state==ACC); it is 1 out of reset.
- State ACC:
  - A transfer occurs on in_valid&&in_ready.
  - sum = acc + zero_extend({in_co, in_sum}), computed at ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0] (wrap-around).
  - ovf <= ovf | sum[ACC_W].
  - cnt <= cnt+1.
  - When the transfer makes cnt reach BATCH:
    - out_acc and out_ovf are loaded with the new values.
    - out_valid <= 1, state -> HOLD.
    - acc, ovf and cnt reset to 0 in the same edge.
  - Latency from the last accepted sample to out_valid=1 is 1 cycle.
- State HOLD:
  - in_ready=0; input samples are ignored and not counted.
  - out_acc and out_ovf stay stable while out_valid=1 && !out_ready.
  - On out_valid&&out_ready: out_valid <= 0, state -> ACC. in_ready returns to 1 the following cycle; there is no bypass.
- clr has priority over every other event in the same cycle: acc=0, ovf=0, cnt=0, out_valid=0, state -> ACC. out_acc and out_ovf keep their last values.
- in_valid may drop without a transfer. The block does not require the source to hold its data.
- BATCH=1: every accepted sample goes straight to HOLD.
- Largest single sample is 2^(DW+1)-1 = 31 for DW=4.
- Reset asserted mid-batch or mid-HOLD: all state returns to its reset values immediately.

Optional Feature:
- Macro SUM_ACCUM_SAT_EN.
- When defined:
  - acc saturates at 2^ACC_W-1 instead of wrapping.
  - ovf is set on the first saturating add.
  - Once acc is saturated it stays at 2^ACC_W-1 until the batch completes or clr is asserted.
- When undefined: acc wraps modulo 2^ACC_W and ovf records the wrap.

Decomposition:
- Shared package holds:
  - The state enum (ACC, HOLD).
  - Default constants DW=4, ACC_W=8, BATCH=4.
  - The localparam SAMPLE_W = DW+1.
- One sub-module: sum_accum_add.
  - Combinational ACC_W-bit add of the zero-extended sample.
  - Produces the next acc value and the overflow bit.
  - Contains the SAT_EN mux.
  - Keeps the arithmetic separate from the handshake FSM.

Test Plan:
- Reset then 4 samples {co,S} = 0_0011, 0_0101, 1_0000, 0_1111 (3, 5, 16, 15) with out_ready=1 -> out_valid pulses 1 cycle after the 4th sample; out_acc=39, out_ovf=0, cnt back to 0.
- 4 samples of 1_1111 (31 each) with ACC_W=6 -> total 124 wraps; out_acc=124 mod 64=60, out_ovf=1. With SUM_ACCUM_SAT_EN defined -> out_acc=63, out_ovf=1.
- Batch completes with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, out_acc stable, no samples counted; out_ready=1 -> out_valid drops, in_ready=1 the next cycle.
- 2 samples accepted, then clr pulse in the same cycle as a third in_valid -> sample dropped, cnt=0. Next batch of 4×1 gives out_acc=4.
- rst_n asserted asynchronously between clock edges while in HOLD -> out_valid=0, in_ready=1 before the next edge, all registers zero.
- Random back-to-back in_valid with random out_ready over 1000 batches -> out_acc matches the scoreboard sum of each 4-sample group mod 256; no sample lost or counted twice.
